// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// requester (i_*) and the load/store requester (d_*). Each access runs a fixed
// IDLE -> ISSUE -> WAIT -> RESP sequence with no overlap between accesses.
// Data requests win arbitration, except that fetch is forced through after
// STARVE_MAX consecutive data grants made while fetch was waiting.

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,

    output logic            m_en,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,

    output logic            busy
);

    localparam int BW = DW / 8;
    localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;

    // Latched description of the access in flight
    logic          owner_d;   // 1 = load/store owns the access, 0 = fetch
    logic          we_q;

    logic          any_req;
    logic          pick_i;
    logic          arb_fire;
    logic          wait_last;

    // Arbitration: data first, fetch only when data is idle or fetch is starved
    always_comb begin
        any_req   = i_req | d_req;
        pick_i    = i_req & (~d_req | (starve_cnt == STARVE_LIM));
        arb_fire  = (state == S_IDLE) & any_req;
        wait_last = (state == S_WAIT) & (cnt == CNT_ONE);
    end

    // Next-state selection for the fixed access sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req)   state_nxt = S_ISSUE;
            S_ISSUE:                state_nxt = S_WAIT;
            S_WAIT:  if (wait_last) state_nxt = S_RESP;
            S_RESP:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winning request's fields at the arbitration edge
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (arb_fire) begin
            if (pick_i) begin
                owner_d <= 1'b0;
                we_q    <= 1'b0;
                m_be    <= '1;
                m_addr  <= i_addr;
                m_wdata <= '0;
            end else begin
                owner_d <= 1'b1;
                we_q    <= d_we;
                m_be    <= d_we ? d_be : {BW{1'b1}};
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= CNT_LOAD;
        end else if (state == S_WAIT) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Starvation counter: counts data wins while fetch waits, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (!i_req || pick_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + STARVE_ONE;
            end
        end
    end

    // Capture read data on the final WAIT edge; stores leave d_rdata untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (wait_last && !we_q) begin
            if (owner_d) begin
                d_rdata <= m_rdata;
            end else begin
                i_rdata <= m_rdata;
            end
        end
    end

    // Strobes decode directly from state so each is exactly one cycle per access
    always_comb begin
        m_en     = (state == S_ISSUE);
        m_we     = m_en & we_q;
        i_gnt    = m_en & ~owner_d;
        d_gnt    = m_en & owner_d;
        i_rvalid = (state == S_RESP) & ~owner_d;
        d_rvalid = (state == S_RESP) & owner_d;
        busy     = (state != S_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance for the main
// scenarios and a MEM_LAT=3 instance for reset during WAIT.

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;

    logic        i_req, i_req3, d_req, d_req3, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3, busy3;
    logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
    logic [3:0]  m_be3;

    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req3), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_be(m_be3), .m_addr(m_addr3), .m_wdata(m_wdata3),
        .m_rdata(m_rdata3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory model shared by both instances; only u_dut writes
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                m_rdata <= mem[m_addr[9:2]];
            end
        end
        if (m_en3) m_rdata3 <= mem[m_addr3[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gexp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int seen, ng, both, nwe, nrv, lat, done;

        rst = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        i_req = 0; i_req3 = 0; d_req = 0; d_req3 = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

        // 1. Reset held for several cycles while the memory is preloaded
        poke(8'd4,  32'h00500093);
        poke(8'd64, 32'h0000ABCD);
        poke(8'd8,  32'h11223344);
        poke(8'd5,  32'hCAFEF00D);
        chk("rst_strobes", 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, busy}), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_m_addr",  m_addr,  32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_be",    32'(m_be), 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin step(); if (m_en) seen++; end
        chk("idle_no_m_en", 32'(seen), 32'd0);

        // 2. Single fetch
        i_addr = 32'h10; i_req = 1'b1;
        step();
        chk("t2_i_gnt", 32'(i_gnt), 32'd1);
        chk("t2_m_en",  32'(m_en),  32'd1);
        chk("t2_m_addr", m_addr, 32'h10);
        chk("t2_m_we_be", 32'({m_we, m_be}), 32'h0F);
        i_req = 1'b0;
        step();
        chk("t2_wait", 32'({m_en, i_rvalid}), 32'd0);
        step();
        chk("t2_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("t2_i_rdata",  i_rdata, 32'h00500093);
        step();
        chk("t2_done", 32'({i_rvalid, busy}), 32'd0);

        // 3. Simultaneous fetch and load: load first, fetch follows
        d_we = 0; d_be = 4'hF; d_addr = 32'h100; d_req = 1'b1;
        i_addr = 32'h10; i_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            logic [3:0] e;
            step();
            case (k)
                1: e = 4'b0100;
                3: e = 4'b0001;
                5: e = 4'b1000;
                7: e = 4'b0010;
                default: e = 4'b0000;
            endcase
            chk($sformatf("t3_cyc%0d", k), 32'({i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'(e));
            if (k == 3) chk("t3_d_rdata", d_rdata, 32'h0000ABCD);
            if (k == 7) chk("t3_i_rdata", i_rdata, 32'h00500093);
            if (d_gnt) d_req = 1'b0;
            if (i_gnt) i_req = 1'b0;
        end
        step();

        // 4. Starvation limit: both requests held continuously
        d_we = 0; d_addr = 32'h100; d_req = 1'b1; i_addr = 32'h10; i_req = 1'b1;
        ng = 0; both = 0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            step();
            if (i_gnt && d_gnt) both++;
            if (i_gnt || d_gnt) begin
                chk($sformatf("t4_grant%0d_is_i", ng), 32'(i_gnt), 32'(gexp_i[ng]));
                ng++;
                if (ng == 10) begin d_req = 1'b0; i_req = 1'b0; end
            end
        end
        chk("t4_grants", 32'(ng), 32'd10);
        chk("t4_both",   32'(both), 32'd0);
        done = 0;
        for (int c = 0; c < 10 && done == 0; c++) begin step(); if (!busy) done = 1; end
        chk("t4_idle", 32'(done), 32'd1);

        // 5. Partial store
        d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        nwe = 0; nrv = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (d_gnt) d_req = 1'b0;
            if (m_we) begin
                nwe++;
                chk("t5_m_en",    32'(m_en), 32'd1);
                chk("t5_m_be",    32'(m_be), 32'h3);
                chk("t5_m_addr",  m_addr, 32'h20);
                chk("t5_m_wdata", m_wdata, 32'hDEADBEEF);
            end
            if (d_rvalid) nrv++;
        end
        chk("t5_we_cycles", 32'(nwe), 32'd1);
        chk("t5_rvalids",   32'(nrv), 32'd1);
        chk("t5_d_rdata",   d_rdata, 32'h0000ABCD);
        chk("t5_mem",       mem[8], 32'h1122BEEF);
        d_we = 0;

        // 6. Reset during WAIT on the MEM_LAT=3 instance, then a clean fetch
        i_addr = 32'h10; i_req3 = 1'b1;
        step();
        chk("t6_i_gnt", 32'(i_gnt3), 32'd1);
        i_req3 = 1'b0;
        step();
        chk("t6_busy_wait", 32'(busy3), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk("t6_idle",    32'({busy3, i_rvalid3, m_en3, m_we3}), 32'd0);
        chk("t6_rdata",   i_rdata3 | d_rdata3, 32'd0);
        chk("t6_m_regs",  m_wdata3 | 32'(m_be3), 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin step(); if (i_rvalid3 || d_rvalid3 || d_gnt3) seen++; end
        chk("t6_no_rvalid", 32'(seen), 32'd0);
        i_addr = 32'h14; i_req3 = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            step();
            if (i_gnt3) i_req3 = 1'b0;
            if (i_rvalid3) lat = c;
        end
        chk("t6_latency", 32'(lat), 32'd5);
        chk("t6_i_rdata", i_rdata3, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
